// File: rtl/sram_bank_arb_if.sv
// Manager-side OBI bus, SRAM bank port and perf counters of the sram_bank_arb arbiter.
// The slave modport is the arbiter's view; the master modport drives the managers and the SRAM read data.
interface sram_bank_arb_if #(
    parameter int unsigned NumMgr       = 2,
    parameter int unsigned BankNumWords = 512
);
    localparam int unsigned BankAddrWidth = (BankNumWords > 1) ? $clog2(BankNumWords) : 1;

    logic [NumMgr-1:0]               mgr_req;
    logic [NumMgr-1:0][31:0]         mgr_addr;
    logic [NumMgr-1:0]               mgr_we;
    logic [NumMgr-1:0][3:0]          mgr_be;
    logic [NumMgr-1:0][31:0]         mgr_wdata;
    logic [NumMgr-1:0]               mgr_gnt;
    logic [NumMgr-1:0]               mgr_rvalid;
    logic [NumMgr-1:0][31:0]         mgr_rdata;
    logic [NumMgr-1:0]               mgr_err;

    logic                            sram_req;
    logic                            sram_we;
    logic [BankAddrWidth-1:0]        sram_addr;
    logic [3:0]                      sram_be;
    logic [31:0]                     sram_wdata;
    logic [31:0]                     sram_rdata;

    logic [NumMgr-1:0][31:0]         perf_gnt_cnt;

    modport master (
        output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata, sram_rdata,
        input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        input  sram_req, sram_we, sram_addr, sram_be, sram_wdata, perf_gnt_cnt
    );

    modport slave (
        input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata, sram_rdata,
        output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        output sram_req, sram_we, sram_addr, sram_be, sram_wdata, perf_gnt_cnt
    );
endinterface

// File: rtl/sram_bank_arb.sv
// Round-robin arbiter sharing one SRAM bank between NumMgr OBI managers, one grant per cycle.
// Optional per-manager grant counters are built only when SRAM_BANK_ARB_PERF_EN is defined.
module sram_bank_arb #(
    parameter int unsigned NumMgr       = 2,
    parameter logic [31:0] BankBaseAddr = 32'h1000_0000,
    parameter int unsigned BankNumWords = 512
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    sram_bank_arb_if.slave bus
);
    localparam int unsigned IdxW          = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned BankAddrWidth = (BankNumWords > 1) ? $clog2(BankNumWords) : 1;
    localparam logic [31:0] BankBytes     = 32'(BankNumWords * 4);
    localparam logic [31:0] ErrRdata      = 32'hBADC_AB1E;

    logic [IdxW-1:0] rr_r;
    logic            gnt_any_s;
    logic [IdxW-1:0] win_idx_s;
    logic [31:0]     win_addr_s;
    logic [31:0]     win_off_s;
    logic            in_range_s;
    logic            sram_req_s;

    logic            rsp_valid_r;
    logic [IdxW-1:0] rsp_idx_r;
    logic            rsp_err_r;
    logic            rsp_we_r;

    // Round-robin search: first requester at or after rr_r wins; nothing is granted in reset.
    always_comb begin
        logic [IdxW-1:0] cand_v;
        logic            hit_v;
        gnt_any_s = 1'b0;
        win_idx_s = '0;
        for (int off = 0; off < int'(NumMgr); off++) begin
            cand_v    = IdxW'((int'(rr_r) + off) % int'(NumMgr));
            hit_v     = rst_ni && !gnt_any_s && bus.mgr_req[cand_v];
            gnt_any_s = gnt_any_s | hit_v;
            win_idx_s = hit_v ? cand_v : win_idx_s;
        end
    end

    // An address below the base wraps to a huge offset, so one compare covers both bounds.
    assign win_addr_s = bus.mgr_addr[win_idx_s];
    assign win_off_s  = win_addr_s - BankBaseAddr;
    assign in_range_s = (win_addr_s >= BankBaseAddr) && (win_off_s < BankBytes);
    assign sram_req_s = gnt_any_s & in_range_s;

    // Grant vector and SRAM request; SRAM command fields are zeroed when no access is issued.
    always_comb begin
        bus.mgr_gnt = '0;
        if (gnt_any_s) begin
            bus.mgr_gnt[win_idx_s] = 1'b1;
        end else begin
            bus.mgr_gnt = '0;
        end
        bus.sram_req = sram_req_s;
        if (sram_req_s) begin
            bus.sram_we    = bus.mgr_we[win_idx_s];
            bus.sram_addr  = win_off_s[BankAddrWidth+1:2];
            bus.sram_be    = bus.mgr_be[win_idx_s];
            bus.sram_wdata = bus.mgr_wdata[win_idx_s];
        end else begin
            bus.sram_we    = 1'b0;
            bus.sram_addr  = '0;
            bus.sram_be    = 4'h0;
            bus.sram_wdata = 32'h0;
        end
    end

    // Round-robin pointer: moves past the winner, holds when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r <= '0;
        end else if (gnt_any_s) begin
            rr_r <= (win_idx_s == IdxW'(NumMgr - 1)) ? '0 : win_idx_s + IdxW'(1);
        end
    end

    // Response-side state for the access granted in the previous cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            rsp_idx_r   <= '0;
            rsp_err_r   <= 1'b0;
            rsp_we_r    <= 1'b0;
        end else begin
            rsp_valid_r <= gnt_any_s;
            rsp_idx_r   <= win_idx_s;
            rsp_err_r   <= gnt_any_s & ~in_range_s;
            rsp_we_r    <= gnt_any_s & bus.mgr_we[win_idx_s];
        end
    end

    // Response fan-out: only the previous winner sees rvalid; everything else stays 0.
    always_comb begin
        bus.mgr_rvalid = '0;
        bus.mgr_err    = '0;
        bus.mgr_rdata  = '0;
        if (rsp_valid_r) begin
            bus.mgr_rvalid[rsp_idx_r] = 1'b1;
            bus.mgr_err[rsp_idx_r]    = rsp_err_r;
            if (rsp_err_r) begin
                bus.mgr_rdata[rsp_idx_r] = ErrRdata;
            end else if (rsp_we_r) begin
                bus.mgr_rdata[rsp_idx_r] = 32'h0;
            end else begin
                bus.mgr_rdata[rsp_idx_r] = bus.sram_rdata;
            end
        end else begin
            bus.mgr_rvalid = '0;
        end
    end

`ifdef SRAM_BANK_ARB_PERF_EN
    logic [NumMgr-1:0][31:0] perf_cnt_r;

    // Per-manager grant counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_r <= '0;
        end else if (gnt_any_s) begin
            perf_cnt_r[win_idx_s] <= perf_cnt_r[win_idx_s] + 32'd1;
        end
    end

    assign bus.perf_gnt_cnt = perf_cnt_r;
`else
    assign bus.perf_gnt_cnt = '0;
`endif

endmodule
